des_iter_sequencer: RTL

//  Drives one shared DES core through an iterated self-test chain.

---
 rtl/des_iter_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/des_iter_sequencer.sv
// Sequencer for an iterated DES self-test: each step feeds X as data and key to a shared
// DES core, alternating encrypt/decrypt, then compares the final X against a reference.
module des_iter_sequencer #(
  parameter int ITERATIONS  = 16,
  parameter int DES_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] seed,
  input  logic [63:0] expected,
  output logic [63:0] des_data,
  output logic [63:0] des_key,
  output logic        des_mode,
  input  logic [63:0] des_result,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        pass,
  output logic [7:0]  step
);
  localparam int            CW        = (DES_LATENCY > 0) ? $clog2(DES_LATENCY + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DES_LATENCY);
  localparam logic [7:0]    STEP_LAST = 8'(ITERATIONS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [63:0]   x_reg, x_nx, result_nx;
  logic [7:0]    step_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          pass_reg, pass_nx, match;

  assign match = (result == expected);

  always_comb begin
    state_nx  = state;
    x_nx      = x_reg;
    step_nx   = step;
    cnt_nx    = cnt;
    result_nx = result;
    pass_nx   = pass_reg;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // abort outranks start: a coincident start is dropped
        if (!abort && start) begin
          x_nx     = seed;
          step_nx  = 8'd0;
          cnt_nx   = '0;
          pass_nx  = 1'b0;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          step_nx  = 8'd0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          x_nx   = des_result;
          cnt_nx = '0;
          if (step == STEP_LAST) begin
            result_nx = des_result;
            state_nx  = DONE;
          end else begin
            step_nx = step + 8'd1;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        if (abort) begin
          step_nx = 8'd0;
          cnt_nx  = '0;
        end else begin
          done    = 1'b1;
          pass_nx = match;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      x_reg    <= '0;
      step     <= '0;
      cnt      <= '0;
      result   <= '0;
      pass_reg <= 1'b0;
    end else begin
      state    <= state_nx;
      x_reg    <= x_nx;
      step     <= step_nx;
      cnt      <= cnt_nx;
      result   <= result_nx;
      pass_reg <= pass_nx;
    end
  end

  assign des_data = x_reg;
  assign des_key  = x_reg;
  assign des_mode = step[0];
  assign busy     = (state != IDLE);
  // pass is live during the done cycle, then held from the register
  assign pass     = done ? match : pass_reg;

endmodule
